fc_argmax_classifier: RTL and testbench

// - Final stage after the last fully-connected layer (84->10). Consumes the 10 signed 16-bit

---
 rtl/fc_argmax_classifier.sv | 169 ++++++++++++++++
 tb/tb_fc_argmax_classifier.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_argmax_classifier.sv
// fc_argmax_classifier: argmax over one frame of signed class scores.
// Scores arrive as a valid/ready stream, one class per beat, in index order.
// The result is held in DONE until the consumer accepts it.
//
// Optional feature macro: FC_ARGMAX_SCORE_EN adds the max_score output.
//
// Ports:
//   clk, reset    rising-edge clock; asynchronous active-low reset
//   enable        start pulse, only sampled in IDLE
//   in_valid/in_ready/in_data/in_last   score stream (signed DATA_W)
//   out_ready     consumer accepts the held result
//   class_valid   result held valid
//   class_idx     index of the maximum score
//   finished      one-cycle pulse on entry to DONE
//   frame_err     frame length / in_last mismatch, sticky until next start
//   busy          high in COLLECT or DONE
//   max_score     winning score (FC_ARGMAX_SCORE_EN only)
module fc_argmax_classifier #(
   parameter int unsigned NUM_CLASSES = 10,
   parameter int unsigned DATA_W      = 16,
   parameter int unsigned IDX_W       = $clog2(NUM_CLASSES)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     enable,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] in_data,
   input  logic                     in_last,
   input  logic                     out_ready,
   output logic                     class_valid,
   output logic [IDX_W-1:0]         class_idx,
   output logic                     finished,
   output logic                     frame_err,
   output logic                     busy
`ifdef FC_ARGMAX_SCORE_EN
   ,
   output logic signed [DATA_W-1:0] max_score
`endif
);

   localparam logic [IDX_W-1:0]         LAST_CNT = IDX_W'(NUM_CLASSES - 1);
   localparam logic signed [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      DONE    = 2'd2
   } state_t;

   state_t                     state_q, state_d;
   logic [IDX_W-1:0]           cnt_q, cnt_d;
   logic signed [DATA_W-1:0]   max_q, max_d;
   logic [IDX_W-1:0]           idx_q, idx_d;
   logic [IDX_W-1:0]           class_idx_d;
   logic                       frame_err_d, in_ready_d, class_valid_d, finished_d, busy_d;
   logic signed [DATA_W-1:0]   beat_max;
   logic [IDX_W-1:0]           beat_idx;
`ifdef FC_ARGMAX_SCORE_EN
   logic signed [DATA_W-1:0]   max_score_d;
`endif

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state, running compare and registered-output next values
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      max_d         = max_q;
      idx_d         = idx_q;
      class_idx_d   = class_idx;
      frame_err_d   = frame_err;
      in_ready_d    = in_ready;
      class_valid_d = class_valid;
      finished_d    = 1'b0;
      busy_d        = busy;
      beat_max      = max_q;
      beat_idx      = idx_q;
`ifdef FC_ARGMAX_SCORE_EN
      max_score_d   = max_score;
`endif
      case (state_q)
         IDLE: begin
            if (enable) begin
               state_d     = COLLECT;
               frame_err_d = 1'b0;
               cnt_d       = '0;
               max_d       = MOST_NEG;
               in_ready_d  = 1'b1;
               busy_d      = 1'b1;
            end
         end
         COLLECT: begin
            if (in_valid && in_ready) begin
               // First beat loads unconditionally; later beats win only when strictly greater
               if (cnt_q == '0) begin
                  beat_max = in_data;
                  beat_idx = '0;
               end else if (in_data > max_q) begin
                  beat_max = in_data;
                  beat_idx = cnt_q;
               end
               max_d = beat_max;
               idx_d = beat_idx;
               if (in_last || (cnt_q == LAST_CNT)) begin
                  state_d       = DONE;
                  in_ready_d    = 1'b0;
                  class_valid_d = 1'b1;
                  finished_d    = 1'b1;
                  // Error unless the full-length beat is also the marked last one
                  frame_err_d   = (cnt_q == LAST_CNT) ? !in_last : 1'b1;
                  class_idx_d   = beat_idx;
`ifdef FC_ARGMAX_SCORE_EN
                  max_score_d   = beat_max;
`endif
               end else begin
                  cnt_d = cnt_q + IDX_W'(1);
               end
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d       = IDLE;
               class_valid_d = 1'b0;
               busy_d        = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q       <= '0;
         max_q       <= MOST_NEG;
         idx_q       <= '0;
         class_idx   <= '0;
         frame_err   <= 1'b0;
         in_ready    <= 1'b0;
         class_valid <= 1'b0;
         finished    <= 1'b0;
         busy        <= 1'b0;
`ifdef FC_ARGMAX_SCORE_EN
         max_score   <= '0;
`endif
      end else begin
         cnt_q       <= cnt_d;
         max_q       <= max_d;
         idx_q       <= idx_d;
         class_idx   <= class_idx_d;
         frame_err   <= frame_err_d;
         in_ready    <= in_ready_d;
         class_valid <= class_valid_d;
         finished    <= finished_d;
         busy        <= busy_d;
`ifdef FC_ARGMAX_SCORE_EN
         max_score   <= max_score_d;
`endif
      end
   end

endmodule

// File: tb/tb_fc_argmax_classifier.sv
// Testbench for fc_argmax_classifier: directed and randomized frames checked
// against an argmax reference model of the frame rules.
module tb_fc_argmax_classifier;

   localparam int unsigned N  = 10;
   localparam int unsigned DW = 16;
   localparam int unsigned IW = $clog2(N);

   logic                 clk;
   logic                 reset;
   logic                 enable;
   logic                 in_valid;
   logic                 in_ready;
   logic signed [DW-1:0] in_data;
   logic                 in_last;
   logic                 out_ready;
   logic                 class_valid;
   logic [IW-1:0]        class_idx;
   logic                 finished;
   logic                 frame_err;
   logic                 busy;
`ifdef FC_ARGMAX_SCORE_EN
   logic signed [DW-1:0] max_score;
`endif

   int errors = 0;
   int checks = 0;
   int fin_cnt = 0;
   int acc_cnt = 0;
   logic signed [DW-1:0] sc [N];

   fc_argmax_classifier #(.NUM_CLASSES(N), .DATA_W(DW)) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_last    (in_last),
      .out_ready  (out_ready),
      .class_valid(class_valid),
      .class_idx  (class_idx),
      .finished   (finished),
      .frame_err  (frame_err),
      .busy       (busy)
`ifdef FC_ARGMAX_SCORE_EN
      ,
      .max_score  (max_score)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Mid-cycle monitors: finished pulses and beats that will be accepted at the next edge
   always @(negedge clk) begin
      if (finished === 1'b1) fin_cnt++;
      if (in_valid === 1'b1 && in_ready === 1'b1) acc_cnt++;
   end

   // Reference: frame ends at first beat with in_last or at beat N-1; argmax with ties to lower index
   function automatic void model(input int last_pos, output int exp_idx, output bit exp_err,
                                 output int n_acc);
      int e;
      int best;
      e = N - 1;
      if (last_pos >= 0 && last_pos < N - 1) e = last_pos;
      n_acc   = e + 1;
      exp_err = !((e == N - 1) && (last_pos == N - 1));
      best = 0;
      for (int j = 1; j < n_acc; j++)
         if (sc[j] > sc[best]) best = j;
      exp_idx = best;
   endfunction

   task automatic start_frame();
      enable = 1'b1;
      @(posedge clk); #1;
      enable = 1'b0;
   endtask

   task automatic send_beats(input int n, input int last_pos, input bit gaps);
      for (int i = 0; i < n; i++) begin
         int t;
         in_valid = 1'b0;
         if (gaps) begin
            int g;
            g = $urandom_range(0, 3);
            repeat (g) begin @(posedge clk); #1; end
         end
         in_valid = 1'b1;
         in_data  = sc[i];
         in_last  = (i == last_pos);
         t = 0;
         while (in_ready !== 1'b1 && t < 50) begin
            @(posedge clk); #1;
            t++;
         end
         if (in_ready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL beat_timeout beat=%0d in_ready=%b required 1", i, in_ready);
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0; enable = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({in_ready, class_valid, finished, frame_err, busy} !== 5'b0 || class_idx !== '0) begin
         errors++;
         $display("FAIL reset_outputs got rdy=%b cv=%b fin=%b err=%b busy=%b idx=%0d required all 0",
                  in_ready, class_valid, finished, frame_err, busy, class_idx);
      end
      reset = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_reset got rdy=%b busy=%b required 0 0", in_ready, busy);
      end
   endtask

   task automatic test_basic();
      int v [N] = '{5, -3, 40, 40, 7, 0, -100, 12, 39, 1};
      int ei, na, f0;
      bit ee;
      for (int i = 0; i < N; i++) sc[i] = DW'(v[i]);
      model(9, ei, ee, na);
      f0 = fin_cnt;
      start_frame();
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL basic_collect got rdy=%b busy=%b required 1 1", in_ready, busy);
      end
      send_beats(na, 9, 1'b0);
      checks++;
      if (class_valid !== 1'b1 || class_idx !== IW'(ei) || frame_err !== ee) begin
         errors++;
         $display("FAIL basic_result got cv=%b idx=%0d err=%b required 1 %0d %b",
                  class_valid, class_idx, frame_err, ei, ee);
      end
      repeat (3) begin @(posedge clk); #1; end
      checks++;
      if (fin_cnt - f0 !== 1 || class_valid !== 1'b1) begin
         errors++;
         $display("FAIL basic_finished got pulses=%0d cv=%b required 1 1", fin_cnt - f0, class_valid);
      end
      release_result();
      checks++;
      if (class_valid !== 1'b0 || busy !== 1'b0 || class_idx !== IW'(ei)) begin
         errors++;
         $display("FAIL basic_release got cv=%b busy=%b idx=%0d required 0 0 %0d",
                  class_valid, busy, class_idx, ei);
      end
   endtask

   task automatic test_all_negative();
      int ei, na;
      bit ee;
      for (int i = 0; i < N; i++) sc[i] = 16'sh8000;
      model(9, ei, ee, na);
      start_frame();
      send_beats(na, 9, 1'b0);
      checks++;
      if (class_idx !== IW'(ei) || frame_err !== ee || class_valid !== 1'b1) begin
         errors++;
         $display("FAIL all_neg got idx=%0d err=%b cv=%b required %0d %b 1",
                  class_idx, frame_err, class_valid, ei, ee);
      end
`ifdef FC_ARGMAX_SCORE_EN
      checks++;
      if (max_score !== 16'sh8000) begin
         errors++;
         $display("FAIL all_neg_score got %h required 8000", max_score);
      end
`endif
      release_result();
   endtask

   task automatic test_early_last();
      int v [5] = '{1, 2, 9, 3, 4};
      int ei, na, a0;
      bit ee;
      for (int i = 0; i < N; i++) sc[i] = (i < 5) ? DW'(v[i]) : DW'(1000);
      model(4, ei, ee, na);
      start_frame();
      send_beats(na, 4, 1'b0);
      checks++;
      if (class_valid !== 1'b1 || class_idx !== IW'(ei) || frame_err !== ee || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL early_result got cv=%b idx=%0d err=%b rdy=%b required 1 %0d %b 0",
                  class_valid, class_idx, frame_err, in_ready, ei, ee);
      end
      // Upstream keeps offering; nothing must be consumed in DONE
      a0 = acc_cnt;
      in_valid = 1'b1; in_data = 16'sh7fff;
      repeat (4) begin @(posedge clk); #1; end
      in_valid = 1'b0;
      checks++;
      if (acc_cnt !== a0 || class_idx !== IW'(ei)) begin
         errors++;
         $display("FAIL early_no_accept got beats=%0d idx=%0d required 0 %0d", acc_cnt - a0, class_idx, ei);
      end
      release_result();
   endtask

   task automatic test_no_last();
      int ei, na;
      bit ee;
      for (int i = 0; i < N - 1; i++) sc[i] = DW'($urandom_range(0, 32766));
      sc[N-1] = 16'sh7fff;
      model(-1, ei, ee, na);
      start_frame();
      send_beats(na, -1, 1'b0);
      checks++;
      if (class_valid !== 1'b1 || class_idx !== IW'(ei) || frame_err !== ee) begin
         errors++;
         $display("FAIL no_last got cv=%b idx=%0d err=%b required 1 %0d %b",
                  class_valid, class_idx, frame_err, ei, ee);
      end
      release_result();
   endtask

   task automatic test_random_gaps();
      for (int f = 0; f < 6; f++) begin
         int ei, na, a0, bad;
         bit ee;
         for (int i = 0; i < N; i++)
            sc[i] = (f % 2 == 0) ? DW'($urandom) : DW'(int'($urandom_range(0, 6)) - 3);
         model(9, ei, ee, na);
         a0 = acc_cnt;
         start_frame();
         send_beats(na, 9, 1'b1);
         checks++;
         if (class_valid !== 1'b1 || class_idx !== IW'(ei) || frame_err !== ee || acc_cnt - a0 !== na) begin
            errors++;
            $display("FAIL gaps_result frame=%0d got cv=%b idx=%0d err=%b beats=%0d required 1 %0d %b %0d",
                     f, class_valid, class_idx, frame_err, acc_cnt - a0, ei, ee, na);
         end
         bad = 0;
         repeat (20) begin
            @(posedge clk); #1;
            if (class_valid !== 1'b1 || class_idx !== IW'(ei)) bad++;
         end
         checks++;
         if (bad != 0) begin
            errors++;
            $display("FAIL gaps_hold frame=%0d unstable_cycles=%0d required 0", f, bad);
         end
         if (f == 5) begin
            // out_ready together with enable in DONE returns to IDLE without restarting
            out_ready = 1'b1; enable = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0; enable = 1'b0;
            @(posedge clk); #1;
            checks++;
            if (busy !== 1'b0 || in_ready !== 1'b0 || class_valid !== 1'b0) begin
               errors++;
               $display("FAIL done_enable got busy=%b rdy=%b cv=%b required 0 0 0", busy, in_ready, class_valid);
            end
         end else begin
            release_result();
            checks++;
            if (class_valid !== 1'b0 || busy !== 1'b0) begin
               errors++;
               $display("FAIL gaps_release frame=%0d got cv=%b busy=%b required 0 0", f, class_valid, busy);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      int ei, na;
      bit ee;
      for (int i = 0; i < N; i++) sc[i] = 16'sd30000;
      start_frame();
      send_beats(7, -1, 1'b0);
      reset = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b0 || busy !== 1'b0 || class_valid !== 1'b0 || class_idx !== '0) begin
         errors++;
         $display("FAIL reset_mid got rdy=%b busy=%b cv=%b idx=%0d required 0 0 0 0",
                  in_ready, busy, class_valid, class_idx);
      end
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) sc[i] = DW'(int'($urandom_range(0, 200)) - 100);
      sc[3] = 16'sd500;
      model(9, ei, ee, na);
      start_frame();
      send_beats(na, 9, 1'b0);
      checks++;
      if (class_valid !== 1'b1 || class_idx !== IW'(ei) || frame_err !== ee) begin
         errors++;
         $display("FAIL reset_restart got cv=%b idx=%0d err=%b required 1 %0d %b",
                  class_valid, class_idx, frame_err, ei, ee);
      end
      release_result();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_all_negative();
      test_early_last();
      test_no_last();
      test_random_gaps();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
